// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Bus widths, hold codes, exception causes and the packed response entry.
package if_stage_pkg;

   localparam int unsigned BUS_ADDR_MEM     = 64;
   localparam int unsigned BUS_DATA_INSTR   = 32;
   localparam int unsigned BUS_HOLD_CODE    = 3;
   localparam int unsigned BUS_EXCEPT_CAUSE = 4;

   localparam logic [BUS_DATA_INSTR-1:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [63:0]               RESET_PC_DEFAULT = 64'h8000_0000;

   typedef enum logic [BUS_HOLD_CODE-1:0] {
      HoldNone = 3'd0,
      HoldPc   = 3'd1,
      HoldIf   = 3'd2,
      HoldId   = 3'd3
   } hold_code_e;

   localparam hold_code_e HOLD_CODE_IF = HoldIf;

   localparam logic [BUS_EXCEPT_CAUSE-1:0] EXCEPT_INSTR_MISALIGN = 4'd0;
   localparam logic [BUS_EXCEPT_CAUSE-1:0] EXCEPT_INSTR_FAULT    = 4'd1;

   typedef struct packed {
      logic [BUS_DATA_INSTR-1:0]   instr;
      logic                        except;
      logic [BUS_EXCEPT_CAUSE-1:0] cause;
   } fetch_rsp_t;

   // A faulting response never exposes the bus data to decode.
   function automatic fetch_rsp_t make_rsp(input logic [BUS_DATA_INSTR-1:0] rdata,
                                           input logic                      err);
      fetch_rsp_t r;
      r.instr  = err ? INSTR_NOP : rdata;
      r.except = err;
      r.cause  = err ? EXCEPT_INSTR_FAULT : EXCEPT_INSTR_MISALIGN;
      return r;
   endfunction

endpackage

// File: rtl/if_ibuf.sv
// Small response FIFO between the fetch bus and the IF/ID register.
// When empty, a same-cycle push can be popped straight through (bypass).
module if_ibuf #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 8,
   parameter int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic [CntW-1:0]  count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             bypass, do_write, do_read;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == CntW'(Depth));
   assign count_o  = count_q;
   assign bypass   = empty_o && push_i && pop_i;
   assign do_read  = pop_i && !empty_o;
   assign do_write = push_i && !bypass && (!full_o || do_read);
   assign data_o   = empty_o ? data_i : mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_read)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_write) wr_ptr_d = ptr_inc(wr_ptr_q);
         count_d = count_q + CntW'(do_write) - CntW'(do_read);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_write && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited req/gnt/rvalid fetch, response buffer,
// redirect/discard handling and the IF/ID output register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int unsigned        ADDR_W     = BUS_ADDR_MEM,
   parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
   parameter int unsigned        IBUF_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [BUS_HOLD_CODE-1:0]    hold_code,
   input  logic                        jmp_en,
   input  logic [ADDR_W-1:0]           jmp_addr,
   output logic                        ifetch_req_o,
   output logic [ADDR_W-1:0]           ifetch_addr_o,
   input  logic                        ifetch_gnt_i,
   input  logic                        ifetch_rvalid_i,
   input  logic [BUS_DATA_INSTR-1:0]   ifetch_rdata_i,
   input  logic                        ifetch_err_i,
   output logic [BUS_DATA_INSTR-1:0]   instr_o,
   output logic [ADDR_W-1:0]           addr_instr_o,
   output logic                        except_o,
   output logic [BUS_EXCEPT_CAUSE-1:0] except_cause_o
);

   localparam int unsigned CntW  = $clog2(IBUF_DEPTH + 1);
   // Back-to-back redirects with a silent bus can stack several windows of dead responses.
   localparam int unsigned DiscW = CntW + 4;
   localparam int unsigned RspW  = $bits(fetch_rsp_t);
   localparam int unsigned EntW  = ADDR_W + RspW;

   logic [ADDR_W-1:0]           pc_q, pc_d;
   logic [ADDR_W-1:0]           rsp_pc_q, rsp_pc_d;
   logic [CntW-1:0]             outstanding_q, outstanding_d, out_acc;
   logic [DiscW-1:0]            discard_q, discard_d, disc_acc;
   logic                        halted_q, halted_d;
   logic                        run_q;
   logic [BUS_DATA_INSTR-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]           addr_instr_q, addr_instr_d;
   logic                        except_q, except_d;
   logic [BUS_EXCEPT_CAUSE-1:0] cause_q, cause_d;

   logic             stall, misalign, gnt_fire, rsp_drop, rsp_live;
   logic             ibuf_push, ibuf_pop, ibuf_empty, ibuf_full, head_valid;
   logic [CntW-1:0]  ibuf_count;
   logic [EntW-1:0]  push_ent, head_ent;
   fetch_rsp_t       push_rsp, head_rsp;
   logic [ADDR_W-1:0] head_pc;

   assign stall    = (hold_code >= HOLD_CODE_IF);
   assign misalign = (jmp_addr[1:0] != 2'b00);
   assign gnt_fire = ifetch_req_o && ifetch_gnt_i;
   assign rsp_drop = ifetch_rvalid_i && (discard_q != '0);
   assign rsp_live = ifetch_rvalid_i && (discard_q == '0);

   assign ifetch_req_o  = run_q && !halted_q &&
                          (({1'b0, outstanding_q} + {1'b0, ibuf_count}) < (CntW + 1)'(IBUF_DEPTH));
   assign ifetch_addr_o = pc_q;

   assign push_rsp   = make_rsp(ifetch_rdata_i, ifetch_err_i);
   assign push_ent   = {rsp_pc_q, push_rsp};
   assign ibuf_push  = rsp_live && !jmp_en;
   assign head_valid = !ibuf_empty || ibuf_push;
   assign ibuf_pop   = !jmp_en && !stall && head_valid;
   assign {head_pc, head_rsp} = head_ent;

   if_ibuf #(
      .Depth (IBUF_DEPTH),
      .Width (EntW),
      .CntW  (CntW)
   ) u_ibuf (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (jmp_en),
      .push_i  (ibuf_push),
      .data_i  (push_ent),
      .pop_i   (ibuf_pop),
      .data_o  (head_ent),
      .count_o (ibuf_count),
      .empty_o (ibuf_empty),
      .full_o  (ibuf_full)
   );

   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      halted_d = halted_q;
      out_acc  = outstanding_q + CntW'(gnt_fire) - CntW'(rsp_live);
      disc_acc = discard_q - DiscW'(rsp_drop);
      outstanding_d = out_acc;
      discard_d     = disc_acc;

      if (gnt_fire) pc_d = pc_q + ADDR_W'(4);
      if (rsp_live) rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      if (ibuf_push && ifetch_err_i) halted_d = 1'b1;

      // Everything still in flight at a redirect belongs to the old stream.
      if (jmp_en) begin
         outstanding_d = '0;
         discard_d     = disc_acc + DiscW'(out_acc);
         halted_d      = misalign;
         if (!misalign) begin
            pc_d     = jmp_addr;
            rsp_pc_d = jmp_addr;
         end
      end
   end

   always_comb begin
      instr_d      = instr_q;
      addr_instr_d = addr_instr_q;
      except_d     = except_q;
      cause_d      = cause_q;
      if (jmp_en) begin
         instr_d  = INSTR_NOP;
         except_d = misalign;
         cause_d  = EXCEPT_INSTR_MISALIGN;
         if (misalign) addr_instr_d = jmp_addr;
      end else if (!stall) begin
         if (head_valid) begin
            instr_d      = head_rsp.instr;
            addr_instr_d = head_pc;
            except_d     = head_rsp.except;
            cause_d      = head_rsp.cause;
         end else begin
            instr_d  = INSTR_NOP;
            except_d = 1'b0;
            cause_d  = EXCEPT_INSTR_MISALIGN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         halted_q      <= 1'b0;
         run_q         <= 1'b0;
         instr_q       <= INSTR_NOP;
         addr_instr_q  <= '0;
         except_q      <= 1'b0;
         cause_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         halted_q      <= halted_d;
         run_q         <= 1'b1;
         instr_q       <= instr_d;
         addr_instr_q  <= addr_instr_d;
         except_q      <= except_d;
         cause_q       <= cause_d;
      end
   end

   assign instr_o        = instr_q;
   assign addr_instr_o   = addr_instr_q;
   assign except_o       = except_q;
   assign except_cause_o = cause_q;

`ifndef SYNTHESIS
   rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
      ifetch_rvalid_i |-> ((outstanding_q != '0) || (discard_q != '0)));
   ibuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      ibuf_push |-> (!ibuf_full || ibuf_pop));
`endif

endmodule
